warp_dispatch_ctrl: RTL and testbench
=====================================

// Module: warp_dispatch_ctrl
// PURPOSE
// - Sole controller of one circular_buffer warp queue (push_buffer/pop_buffer/read_buffer/data_in/data_out/at_capacity).
// - Shares the push side among NUM_REQ warp producers with a round-robin arbiter.
// - Sequences the pop side as read -> present -> pop toward one core using a valid/ready handshake.
// - Tracks occupancy itself, because the buffer exports only at_capacity.
// PARAMETERS
// - NUM_REQ  4          number of producer requesters (>=2)
// - SIZE     8          depth of the controlled circular_buffer; must equal its size parameter
// - T        warp_reg_t entry type, taken from gpu_pkg
// PORTS
// - clk          in   1                clock, all state updates on posedge
// - rst          in   1                reset, synchronous, active-low (rst==0 at posedge resets)
// - req          in   NUM_REQ          producer i requests to enqueue req_data[i]
// - req_data     in   NUM_REQ x T      per-producer entry
// - grant        out  NUM_REQ          one-hot, combinational; entry of granted producer written this cycle
// - disp_valid   out  1                disp_data holds the queue head
// - disp_data    out  T                head entry, stable while disp_valid && !disp_ready
// - disp_ready   in   1                core accepts head this cycle
// - occupancy    out  $clog2(SIZE+1)   registered entry count, 0..SIZE
// - push_buffer  out  1                to buffer
// - pop_buffer   out  1                to buffer
// - read_buffer  out  1                to buffer
// - buf_data_in  out  T                to buffer data_in
// - buf_data_out in   T                from buffer data_out; valid the cycle after read_buffer
// - at_capacity  in   1                from buffer
// BEHAVIOUR
// - Reset (rst==0 at posedge):
//   - state=IDLE, occupancy=0, rr_ptr=0.
//   - All outputs 0 in the following cycle.
//   - The buffer shares the same rst, so a mid-operation reset discards queued entries and any in-flight dispatch.
// - Push side (combinational, every cycle):
//   - can_push = !at_capacity && occupancy!=SIZE.
//   - If can_push, grant the first asserted req scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ); otherwise grant=0.
//   - push_buffer = |grant; buf_data_in = req_data[granted] (0 when no grant).
//   - On a grant to index g: rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
// - Dispatch FSM:
//   - IDLE: all dispatch outputs 0. occupancy>0 -> READ.
//   - READ: read_buffer=1 for exactly one cycle -> WAIT.
//   - WAIT: disp_valid=1, disp_data=buf_data_out.
//     - disp_ready=1: pop_buffer=1 this cycle -> IDLE.
//     - disp_ready=0: stay in WAIT, data held.
//   - A new head needs at least one IDLE cycle, so back-to-back dispatches occur every 3 cycles.
// - Latency: a push granted in cycle 0 gives occupancy=1 in cycle 1, READ in cycle 2 and disp_valid in cycle 3 (queue was empty, FSM in IDLE).
// - Occupancy update:
//   - push only: +1.
//   - pop only: -1.
//   - push and pop in the same cycle: unchanged. This is legal, including at occupancy==SIZE: the pop frees no slot that cycle, so can_push=0 and no push occurs.
// - Never underflows: pop only in WAIT, which is reachable only with occupancy>=1. Never exceeds SIZE.
// - Wrap-around of head/tail is internal to the buffer; the controller sees only the count.
// - If at_capacity=1 while occupancy<SIZE (buffer/controller mismatch), pushes are blocked. No other action.
// STRUCTURE
// - gpu_pkg: warp_reg_t, and the dispatch state enum {IDLE, READ, WAIT}.
// - rr_arbiter #(N): inputs req, enable, ptr; output one-hot grant. Purely combinational.
//   The rr_ptr register lives in warp_dispatch_ctrl.
// - Top: instantiates rr_arbiter, holds the FSM and the occupancy counter. The circular_buffer is instantiated by the parent.
// TESTING (bench instantiates circular_buffer size 8 + this block, NUM_REQ=4)
// - Reset: hold rst=0 2 cycles with req=4'hF -> grant=0, occupancy=0, disp_valid=0, no buffer strobes.
// - Fairness: req=4'hF continuously, disp_ready=0 -> grants 0,1,2,3,0,... one per cycle.
//   Stops after 8 pushes: occupancy=8, grant=0 while at_capacity=1.
// - Ordering: producer 2 pushes 8'h05, then producer 0 pushes 8'h06, disp_ready=1 -> disp_data 8'h05 then 8'h06.
//   First disp_valid exactly 3 cycles after the first push.
// - Backpressure: disp_ready=0 for 5 cycles in WAIT -> disp_data stable, pop_buffer=0, FSM stays in WAIT.
//   Then disp_ready=1 for 1 cycle -> one pop, occupancy decrements by 1.
// - Full + simultaneous: fill to 8, req=4'h1, assert disp_ready -> pop cycle occupancy stays 8 with no push.
//   Next cycle grant=4'h1, occupancy back to 8.
// - Mid-op reset: rst=0 during WAIT with occupancy=3 -> next cycle IDLE, occupancy=0, disp_valid=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared warp entry type and dispatch state encoding
package gpu_pkg;

    typedef logic [7:0] warp_reg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } disp_state_t;

endpackage

// File: rtl/circular_buffer.sv
// rtl/circular_buffer.sv - FIFO storage with registered read port and full flag
module circular_buffer
    import gpu_pkg::*;
#(
    parameter int  size = 8,
    parameter type T    = warp_reg_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_buffer,
    input  logic pop_buffer,
    input  logic read_buffer,
    input  T     data_in,
    output T     data_out,
    output logic at_capacity
);

    localparam int AW = $clog2(size);
    localparam int CW = $clog2(size + 1);

    T              mem [size];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign at_capacity = (count == CW'(size));
    assign do_push     = push_buffer && !at_capacity;
    assign do_pop      = pop_buffer && (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (read_buffer) data_out <= mem[head];
            if (do_push) tail <= (tail == AW'(size - 1)) ? '0 : tail + 1'b1;
            if (do_pop)  head <= (head == AW'(size - 1)) ? '0 : head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, scan starts at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic                 enable,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_dispatch_ctrl.sv
// rtl/warp_dispatch_ctrl.sv - arbitrates producer pushes and sequences head dispatch to one core
module warp_dispatch_ctrl
    import gpu_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  SIZE    = 8,
    parameter type T       = warp_reg_t
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  T                          req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]        grant,
    output logic                      disp_valid,
    output T                          disp_data,
    input  logic                      disp_ready,
    output logic [$clog2(SIZE+1)-1:0] occupancy,
    output logic                      push_buffer,
    output logic                      pop_buffer,
    output logic                      read_buffer,
    output T                          buf_data_in,
    input  T                          buf_data_out,
    input  logic                      at_capacity
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int OW = $clog2(SIZE + 1);

    disp_state_t   state_q;
    disp_state_t   state_d;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] g_idx;
    logic          can_push;

    // Grants are suppressed while reset is asserted so nothing is strobed into the buffer.
    assign can_push = !at_capacity && (occupancy != OW'(SIZE));

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (req),
        .enable (rst && can_push),
        .ptr    (rr_ptr),
        .grant  (grant)
    );

    assign push_buffer = |grant;

    always_comb begin
        g_idx       = '0;
        buf_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx       = PW'(i);
                buf_data_in = req_data[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        read_buffer = 1'b0;
        pop_buffer  = 1'b0;
        disp_valid  = 1'b0;
        disp_data   = '0;
        case (state_q)
            IDLE: begin
                if (occupancy != '0) state_d = READ;
            end
            READ: begin
                read_buffer = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                disp_valid = 1'b1;
                disp_data  = buf_data_out;
                if (disp_ready) begin
                    pop_buffer = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            occupancy <= '0;
            rr_ptr    <= '0;
        end else begin
            state_q <= state_d;
            if (push_buffer)
                rr_ptr <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
            case ({push_buffer, pop_buffer})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_warp_dispatch_ctrl.sv
// tb/tb_warp_dispatch_ctrl.sv - directed self-checking bench for warp_dispatch_ctrl with an 8-deep buffer
module tb_warp_dispatch_ctrl;
    import gpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    warp_reg_t  req_data [4];
    logic [3:0] grant;
    logic       disp_valid;
    warp_reg_t  disp_data;
    logic       disp_ready;
    logic [3:0] occupancy;
    logic       push_buffer, pop_buffer, read_buffer;
    warp_reg_t  buf_data_in, buf_data_out;
    logic       at_capacity;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    warp_dispatch_ctrl #(.NUM_REQ(4), .SIZE(8), .T(warp_reg_t)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .grant        (grant),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .disp_ready   (disp_ready),
        .occupancy    (occupancy),
        .push_buffer  (push_buffer),
        .pop_buffer   (pop_buffer),
        .read_buffer  (read_buffer),
        .buf_data_in  (buf_data_in),
        .buf_data_out (buf_data_out),
        .at_capacity  (at_capacity)
    );

    circular_buffer #(.size(8), .T(warp_reg_t)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_buffer (push_buffer),
        .pop_buffer  (pop_buffer),
        .read_buffer (read_buffer),
        .data_in     (buf_data_in),
        .data_out    (buf_data_out),
        .at_capacity (at_capacity)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        req = 4'h0;
        disp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'hF;
        disp_ready = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i] = 8'hA0 + 8'(i);
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            total++;
            if (grant !== 4'h0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
            total++;
            if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
            total++;
            if (disp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", disp_valid); end
            total++;
            if ({push_buffer, pop_buffer, read_buffer} !== 3'b000) begin
                bad++; $display("FAIL reset_strobes got=%b exp=000", {push_buffer, pop_buffer, read_buffer});
            end
        end
        req = 4'h0;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        reset_dut();
        for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
        req = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_g = 4'b0001 << (c % 4);
            total++;
            if (grant !== exp_g) begin bad++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
            tick();
        end
        #1;
        total++;
        if (occupancy !== 4'd8) begin bad++; $display("FAIL fair_occ got=%0d exp=8", occupancy); end
        total++;
        if (at_capacity !== 1'b1) begin bad++; $display("FAIL fair_full got=%b exp=1", at_capacity); end
        total++;
        if (grant !== 4'h0) begin bad++; $display("FAIL fair_blocked got=%b exp=0000", grant); end
        total++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h10) begin
            bad++; $display("FAIL fair_head got=%b/%h exp=1/10", disp_valid, disp_data);
        end
        req = 4'h0;
    endtask

    task automatic test_ordering();
        reset_dut();
        disp_ready = 1'b1;
        req = 4'b0100;
        req_data[2] = 8'h05;
        #1;
        total++;
        if (grant !== 4'b0100) begin bad++; $display("FAIL ord_grant0 got=%b exp=0100", grant); end
        tick();
        req = 4'b0001;
        req_data[0] = 8'h06;
        #1;
        total++;
        if (grant !== 4'b0001 || disp_valid !== 1'b0) begin
            bad++; $display("FAIL ord_grant1 got=%b/%b exp=0001/0", grant, disp_valid);
        end
        tick();
        req = 4'h0;
        #1;
        total++;
        if (read_buffer !== 1'b1 || disp_valid !== 1'b0) begin
            bad++; $display("FAIL ord_read got=%b/%b exp=1/0", read_buffer, disp_valid);
        end
        tick();
        total++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h05 || pop_buffer !== 1'b1) begin
            bad++; $display("FAIL ord_first got=%b/%h/%b exp=1/05/1", disp_valid, disp_data, pop_buffer);
        end
        tick();
        total++;
        if (disp_valid !== 1'b0 || occupancy !== 4'd1) begin
            bad++; $display("FAIL ord_gap got=%b/%0d exp=0/1", disp_valid, occupancy);
        end
        tick();
        tick();
        total++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h06) begin
            bad++; $display("FAIL ord_second got=%b/%h exp=1/06", disp_valid, disp_data);
        end
        tick();
        total++;
        if (occupancy !== 4'd0) begin bad++; $display("FAIL ord_drained got=%0d exp=0", occupancy); end
        disp_ready = 1'b0;
    endtask

    task automatic push_three();
        req = 4'b0001;
        req_data[0] = 8'h21;
        tick();
        req_data[0] = 8'h22;
        tick();
        req_data[0] = 8'h23;
        tick();
        req = 4'h0;
    endtask

    task automatic test_backpressure();
        reset_dut();
        push_three();
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (disp_valid !== 1'b1 || disp_data !== 8'h21 || pop_buffer !== 1'b0 || read_buffer !== 1'b0) begin
                bad++; $display("FAIL bp_hold c=%0d got=%b/%h/%b/%b exp=1/21/0/0",
                                c, disp_valid, disp_data, pop_buffer, read_buffer);
            end
            tick();
        end
        disp_ready = 1'b1;
        #1;
        total++;
        if (pop_buffer !== 1'b1 || occupancy !== 4'd3) begin
            bad++; $display("FAIL bp_pop got=%b/%0d exp=1/3", pop_buffer, occupancy);
        end
        tick();
        disp_ready = 1'b0;
        #1;
        total++;
        if (occupancy !== 4'd2 || disp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_after got=%0d/%b exp=2/0", occupancy, disp_valid);
        end
    endtask

    task automatic test_full_simultaneous();
        reset_dut();
        req_data[0] = 8'h33;
        req = 4'h1;
        for (int c = 0; c < 8; c++) tick();
        #1;
        total++;
        if (occupancy !== 4'd8 || grant !== 4'h0) begin
            bad++; $display("FAIL full_fill got=%0d/%b exp=8/0000", occupancy, grant);
        end
        disp_ready = 1'b1;
        #1;
        total++;
        if (pop_buffer !== 1'b1 || push_buffer !== 1'b0 || grant !== 4'h0 || occupancy !== 4'd8) begin
            bad++; $display("FAIL full_popcycle got=%b/%b/%b/%0d exp=1/0/0000/8",
                            pop_buffer, push_buffer, grant, occupancy);
        end
        tick();
        disp_ready = 1'b0;
        #1;
        total++;
        if (grant !== 4'h1 || occupancy !== 4'd7) begin
            bad++; $display("FAIL full_refill got=%b/%0d exp=0001/7", grant, occupancy);
        end
        tick();
        total++;
        if (occupancy !== 4'd8 || grant !== 4'h0) begin
            bad++; $display("FAIL full_back got=%0d/%b exp=8/0000", occupancy, grant);
        end
        req = 4'h0;
    endtask

    task automatic test_midop_reset();
        reset_dut();
        push_three();
        #1;
        total++;
        if (disp_valid !== 1'b1 || occupancy !== 4'd3) begin
            bad++; $display("FAIL mid_pre got=%b/%0d exp=1/3", disp_valid, occupancy);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (occupancy !== 4'd0 || disp_valid !== 1'b0 || read_buffer !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", occupancy, disp_valid, read_buffer);
        end
        tick();
        total++;
        if (read_buffer !== 1'b0 || at_capacity !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL mid_idle got=%b/%b/%0d exp=0/0/0", read_buffer, at_capacity, occupancy);
        end
    endtask

    initial begin
        rst = 1'b0;
        req = 4'h0;
        disp_ready = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i] = '0;
        test_reset();
        test_fairness();
        test_ordering();
        test_backpressure();
        test_full_simultaneous();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
